// File: rtl/traffic_pkg.sv
// Shared phase encoding, light constants and decode helpers for the traffic phase controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,   // main green
        S1 = 2'b01,   // main yellow
        S2 = 2'b10,   // side green
        S3 = 2'b11    // side yellow
    } phase_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Fixed rotation order of the four phases.
    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            S0:      n = S1;
            S1:      n = S2;
            S2:      n = S3;
            default: n = S0;
        endcase
        return n;
    endfunction

    // Returns {main_light, side_light}; only one road is ever non-red.
    function automatic logic [5:0] light_decode(input phase_t p);
        logic [5:0] l;
        case (p)
            S0:      l = {GRN, RED};
            S1:      l = {YEL, RED};
            S2:      l = {RED, GRN};
            default: l = {RED, YEL};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Per-phase cycle counter: clears on phase change, saturates once the phase duration is reached.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_dur,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full
);

    logic [CNT_W-1:0] r_cnt;

    // i_dur is never zero, so dur-1 cannot underflow; >= keeps full asserted
    // when a shortened duration drops below the running count.
    assign o_full = (r_cnt >= (i_dur - CNT_W'(1)));
    assign o_cnt  = r_cnt;

    // Count up each cycle, hold at the limit, restart at every phase change.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (!o_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-phase main/side road traffic light controller with programmable phase durations.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int T0    = 8,
    parameter int T1    = 3,
    parameter int T2    = 6,
    parameter int T3    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic [1:0]       state,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             phase_done,
    output logic [CNT_W-1:0] cnt
);

    phase_t           r_state;
    logic [CNT_W-1:0] r_dur [4];
    logic             r_phase_done;
    logic [2:0]       r_main;
    logic [2:0]       r_side;

    logic [CNT_W-1:0] w_dur_cur;
    logic [CNT_W-1:0] w_cnt;
    logic             w_full;
    logic             w_adv;
    phase_t           w_next;
    logic [5:0]       w_lights_next;

    // A zero duration would make dur-1 wrap, so it is stored as one cycle.
    function automatic logic [CNT_W-1:0] coerce_dur(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Full compare uses the duration held before any same-cycle write.
    assign w_dur_cur     = r_dur[r_state];
    assign w_adv         = w_full && ((r_state != S0) || c);
    assign w_next        = w_adv ? next_phase(r_state) : r_state;
    assign w_lights_next = light_decode(w_next);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_adv),
        .i_dur   (w_dur_cur),
        .o_cnt   (w_cnt),
        .o_full  (w_full)
    );

    // Phase FSM, duration registers and registered Moore light outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S0;
            r_phase_done <= 1'b0;
            r_main       <= GRN;
            r_side       <= RED;
            r_dur[0]     <= coerce_dur(CNT_W'(T0));
            r_dur[1]     <= coerce_dur(CNT_W'(T1));
            r_dur[2]     <= coerce_dur(CNT_W'(T2));
            r_dur[3]     <= coerce_dur(CNT_W'(T3));
        end else begin
            r_state      <= w_next;
            r_phase_done <= w_adv;
            r_main       <= w_lights_next[5:3];
            r_side       <= w_lights_next[2:0];
            if (cfg_we) begin
                r_dur[cfg_sel] <= coerce_dur(cfg_data);
            end
        end
    end

    assign state      = r_state;
    assign main_light = r_main;
    assign side_light = r_side;
    assign phase_done = r_phase_done;
    assign cnt        = w_cnt;

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter: CNT_W, 8, width of phase counter and duration registers.
REQ-002 Parameter: T0, 8, default main-green minimum duration in cycles.
REQ-003 Parameter: T1, 3, default main-yellow duration in cycles.
REQ-004 Parameter: T2, 6, default side-green duration in cycles.
REQ-005 Parameter: T3, 3, default side-yellow duration in cycles.
REQ-006 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Port: c  input  1  side-road car sensor, pre-synchronised externally.
REQ-009 Port: cfg_we  input  1  duration write strobe.
REQ-010 Port: cfg_sel  input  2  index of duration register written (0..3 = S0..S3).
REQ-011 Port: cfg_data  input  CNT_W  duration value written.
REQ-012 Port: state  output  2  current phase, S0=00, S1=01, S2=10, S3=11.
REQ-013 Port: main_light  output  3  {R,Y,G} one-hot for main road.
REQ-014 Port: side_light  output  3  {R,Y,G} one-hot for side road.
REQ-015 Port: phase_done  output  1  one-cycle pulse in the first cycle of each new phase.
REQ-016 Port: cnt  output  CNT_W  cycles elapsed in current phase.

Function
REQ-017 Durations dur[0..3] SHALL be registers; full = (cnt >= dur[state]-1), using the value stored before any same-cycle write.
REQ-018 S0: full & c -> S1; full & !c -> stay S0, cnt held (saturated); else stay, cnt+1.
REQ-019 S1->S2, S2->S3, S3->S0 SHALL occur on the edge where full=1; otherwise stay, cnt+1.
REQ-020 Every state change SHALL clear cnt to 0 on the same edge.
REQ-021 phase_done SHALL be registered, high exactly in the first cycle of a new phase, low otherwise.
REQ-022 Lights SHALL be Moore-decoded from state: S0 main 001/side 100; S1 main 010/side 100; S2 main 100/side 001; S3 main 100/side 010.
REQ-023 main_light and side_light SHALL never both carry a non-red value.
REQ-024 cfg_we=1 SHALL write dur[cfg_sel] on that edge; cfg_data=0 SHALL be stored as 1.
REQ-025 A write reducing dur[state] to <= cnt SHALL make full=1 from the next cycle (no underflow, no wrap).
REQ-026 cnt SHALL never exceed dur[state]-1 except transiently after REQ-025 writes; it SHALL never wrap.
REQ-027 c is level-sensitive; a one-cycle c pulse coinciding with full in S0 SHALL trigger S0->S1.

Reset
REQ-028 On reset=1 at an edge: state=S0, cnt=0, phase_done=0, dur[i]=Ti (0 coerced to 1), main_light=001, side_light=100.
REQ-029 Reset SHALL override cfg_we and any pending transition in the same cycle, from any state.

Structure
REQ-030 Shared package traffic_pkg SHALL hold the phase typedef (S0..S3 encodings) and light constants RED=100, YEL=010, GRN=001.
REQ-031 One sub-module phase_timer SHALL implement cnt, clear, saturation and the full compare; FSM, duration registers and light decode stay in the top.

Verification (T0=4, T1=2, T2=3, T3=2)
REQ-032 Reset, c=0 for 20 cycles -> state=00 throughout, main=001, side=100, phase_done never high, cnt saturates at 3.
REQ-033 c=1 from reset release (cycle 0) -> S1 at cycle 4, S2 at 6, S3 at 9, S0 at 11; phase_done high at cycles 4, 6, 9, 11 only.
REQ-034 c=0 until cycle 10, c=1 for cycle 10 only -> state=01 at cycle 11, cnt=0.
REQ-035 cfg_we=1, cfg_sel=2, cfg_data=0 while in S0, then c=1 -> S2 lasts exactly 1 cycle.
REQ-036 In S0 with cnt=3, c=0, write dur[0]=2 -> no underflow; c=1 next cycle -> S1 on following edge.
REQ-037 reset=1 for one cycle during S2 with cnt=1, simultaneous cfg_we -> next cycle state=00, cnt=0, lights 001/100, all durations back to 4/2/3/2.
